// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the Data_Memory line-port arbiter.
package dmem_arb_pkg;

    localparam int unsigned DefLineW = 256;
    localparam int unsigned DefAddrW = 32;

    typedef enum logic [1:0] {
        StIdle,
        StBusy0,
        StBusy1,
        StRelease
    } arb_state_e;

    localparam logic [1:0] GntNone  = 2'b00;
    localparam logic [1:0] GntPort0 = 2'b01;
    localparam logic [1:0] GntPort1 = 2'b10;

endpackage

// File: rtl/dmem_arb_watchdog.sv
// Ack-timeout watchdog: saturating cycle counter that flags expiry while a transaction runs.
module dmem_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned     CntW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == CntMax);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the Data_Memory line port (port 0 = D-cache, port 1 = I-cache).
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin priority; otherwise port 0 always wins.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned LINE_W         = DefLineW,
    parameter int unsigned ADDR_W         = DefAddrW,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_req_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [LINE_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic [LINE_W-1:0] m0_data_o,
    input  logic              m1_req_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [LINE_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [LINE_W-1:0] m1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic [1:0]        grant_o,
    output logic              timeout_err_o
);

    arb_state_e state_q, state_d;
    logic       err_q, err_d;
    logic       busy0, busy1, busy;
    logic       expired, done, pick1;

    assign busy0 = (state_q == StBusy0);
    assign busy1 = (state_q == StBusy1);
    assign busy  = busy0 || busy1;
    // Ack takes precedence over a same-cycle expiry.
    assign done  = busy && (mem_ack_i || expired);

    dmem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .run_i    (busy),
        .clear_i  (!busy || done),
        .expired_o(expired)
    );

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic ptr_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_q <= 1'b0;
        end else if (done) begin
            ptr_q <= ~ptr_q;
        end
    end

    assign pick1 = m1_req_i && (!m0_req_i || ptr_q);
`else
    assign pick1 = m1_req_i && !m0_req_i;
`endif

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (m0_req_i || m1_req_i) begin
                    state_d = pick1 ? StBusy1 : StBusy0;
                end
            end
            StBusy0, StBusy1: begin
                if (done) begin
                    state_d = StRelease;
                end
            end
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (busy && expired && !mem_ack_i) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        mem_enable_o = busy;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        grant_o      = GntNone;
        if (busy0) begin
            mem_write_o = m0_write_i;
            mem_addr_o  = m0_addr_i;
            mem_data_o  = m0_data_i;
            grant_o     = GntPort0;
        end else if (busy1) begin
            mem_write_o = m1_write_i;
            mem_addr_o  = m1_addr_i;
            mem_data_o  = m1_data_i;
            grant_o     = GntPort1;
        end
    end

    // A requester that dropped its request mid-transaction gets no ack.
    assign m0_ack_o      = busy0 && mem_ack_i && m0_req_i;
    assign m1_ack_o      = busy1 && mem_ack_i && m1_req_i;
    assign m0_data_o     = m0_ack_o ? mem_data_i : '0;
    assign m1_data_o     = m1_ack_o ? mem_data_i : '0;
    assign timeout_err_o = err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small 4-line memory model and programmable ack delay.
module tb_dmem_port_arbiter;

    localparam int unsigned LineW   = 256;
    localparam int unsigned AddrW   = 32;
    localparam int unsigned Timeout = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              m0_req_i, m0_write_i, m0_ack_o;
    logic [AddrW-1:0]  m0_addr_i;
    logic [LineW-1:0]  m0_data_i, m0_data_o;
    logic              m1_req_i, m1_write_i, m1_ack_o;
    logic [AddrW-1:0]  m1_addr_i;
    logic [LineW-1:0]  m1_data_i, m1_data_o;
    logic              mem_enable_o, mem_write_o, mem_ack_i;
    logic [AddrW-1:0]  mem_addr_o;
    logic [LineW-1:0]  mem_data_o, mem_data_i;
    logic [1:0]        grant_o;
    logic              timeout_err_o;

    int                n_tests = 0;
    int                n_fail  = 0;
    int                ack_dly = 0;
    int                mcnt;
    logic              stray = 1'b0;
    logic [LineW-1:0]  mem [4];
    logic [1:0]        exp_own [4];
    logic [1:0]        owners [4];
    logic [1:0]        exp_g [7];

    dmem_port_arbiter #(
        .LINE_W        (LineW),
        .ADDR_W        (AddrW),
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .m0_req_i     (m0_req_i),
        .m0_write_i   (m0_write_i),
        .m0_addr_i    (m0_addr_i),
        .m0_data_i    (m0_data_i),
        .m0_ack_o     (m0_ack_o),
        .m0_data_o    (m0_data_o),
        .m1_req_i     (m1_req_i),
        .m1_write_i   (m1_write_i),
        .m1_addr_i    (m1_addr_i),
        .m1_data_i    (m1_data_i),
        .m1_ack_o     (m1_ack_o),
        .m1_data_o    (m1_data_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i),
        .grant_o      (grant_o),
        .timeout_err_o(timeout_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [LineW-1:0] line_pat(input int i);
        return {8{32'hCAFE_0000 | 32'(i)}};
    endfunction

    // Memory model: acks in the ack_dly-th enabled cycle (0 = never), line index = addr[6:5].
    assign mem_ack_i  = stray | (mem_enable_o & (ack_dly != 0) & (mcnt == ack_dly - 1));
    assign mem_data_i = mem[mem_addr_o[6:5]];

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcnt <= 0;
            for (int i = 0; i < 4; i++) mem[i] <= line_pat(i);
        end else begin
            mcnt <= mem_enable_o ? mcnt + 1 : 0;
            if (mem_ack_i && mem_write_o) mem[mem_addr_o[6:5]] <= mem_data_o;
        end
    end

    task automatic check(input string tag, input logic [LineW-1:0] got,
                         input logic [LineW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int port, input logic val);
        if (port == 0) m0_req_i = val;
        else m1_req_i = val;
    endtask

    // One transaction on one port; checks every busy cycle and the totals at RELEASE.
    task automatic txn(input string tag, input int port, input logic wr,
                       input logic [AddrW-1:0] addr, input logic [LineW-1:0] wdata,
                       input int dly, input int drop_at, input int exp_busy, input int exp_acks,
                       input logic [LineW-1:0] exp_rdata);
        int   busy = 0;
        int   acks = 0;
        bit   done = 1'b0;
        logic own_ack, oth_ack;
        logic [LineW-1:0] own_data, oth_data;
        logic [1:0] g;
        g       = (port == 0) ? 2'b01 : 2'b10;
        ack_dly = dly;
        if (port == 0) begin
            m0_write_i = wr; m0_addr_i = addr; m0_data_i = wdata;
        end else begin
            m1_write_i = wr; m1_addr_i = addr; m1_data_i = wdata;
        end
        set_req(port, 1'b1);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk_i);
            own_ack  = (port == 0) ? m0_ack_o : m1_ack_o;
            own_data = (port == 0) ? m0_data_o : m1_data_o;
            oth_ack  = (port == 0) ? m1_ack_o : m0_ack_o;
            oth_data = (port == 0) ? m1_data_o : m0_data_o;
            if (mem_enable_o) begin
                busy++;
                check({tag, " grant"}, 256'(grant_o), 256'(g));
                check({tag, " mem_write"}, 256'(mem_write_o), 256'(wr));
                check({tag, " mem_addr"}, 256'(mem_addr_o), 256'(addr));
                check({tag, " mem_data"}, mem_data_o, wdata);
                check({tag, " other ack"}, 256'(oth_ack), 256'(0));
                check({tag, " other data"}, oth_data, '0);
                if (own_ack) begin
                    acks++;
                    if (!wr) check({tag, " rdata"}, own_data, exp_rdata);
                    set_req(port, 1'b0);
                end
                if (busy == drop_at) set_req(port, 1'b0);
            end else if (busy > 0) begin
                done = 1'b1;
                check({tag, " release grant"}, 256'(grant_o), 256'(0));
            end
        end
        check({tag, " completed"}, 256'(done), 256'(1));
        check({tag, " busy cycles"}, 256'(busy), 256'(exp_busy));
        check({tag, " ack count"}, 256'(acks), 256'(exp_acks));
        set_req(port, 1'b0);
    endtask

    initial begin
        int   busy;
        int   n;
        bit   fin;
        logic prev;
        rst_i = 1'b0;
        m0_req_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = '0; m0_data_i = '0;
        m1_req_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = '0; m1_data_i = '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp_own = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_own = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        exp_g = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00};

        repeat (2) @(negedge clk_i);
        check("reset grant", 256'(grant_o), 256'(0));
        check("reset enable", 256'(mem_enable_o), 256'(0));
        check("reset err", 256'(timeout_err_o), 256'(0));
        check("reset addr", 256'(mem_addr_o), 256'(0));
        rst_i = 1'b1;
        @(negedge clk_i);
        check("idle grant", 256'(grant_o), 256'(0));

        // Simultaneous requests: port 0 first, RELEASE and IDLE gaps, then port 1.
        ack_dly = 2;
        m0_addr_i = 32'h40; m1_addr_i = 32'h80;
        m0_req_i = 1'b1; m1_req_i = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk_i);
            check($sformatf("prio grant c%0d", c), 256'(grant_o), 256'(exp_g[c]));
            check($sformatf("prio enable c%0d", c), 256'(mem_enable_o), 256'(exp_g[c] != 2'b00));
            if (m0_ack_o) begin
                check("prio m0 rdata", m0_data_o, line_pat(2));
                m0_req_i = 1'b0;
            end
            if (m1_ack_o) begin
                check("prio m1 rdata", m1_data_o, line_pat(0));
                m1_req_i = 1'b0;
            end
        end
        check("prio reqs served", 256'({m0_req_i, m1_req_i}), 256'(0));

        // Both ports requesting continuously for four transactions.
        ack_dly = 1;
        m0_addr_i = 32'h0; m1_addr_i = 32'h20;
        m0_req_i = 1'b1; m1_req_i = 1'b1;
        n = 0; fin = 1'b0; prev = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk_i);
            if (mem_enable_o && !prev && n < 4) begin
                owners[n] = grant_o;
                n++;
            end
            if (!mem_enable_o && n == 4) fin = 1'b1;
            prev = mem_enable_o;
        end
        check("contend finished", 256'(fin), 256'(1));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("contend owner %0d", i), 256'(owners[i]), 256'(exp_own[i]));
        end
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        @(negedge clk_i);

        txn("rd0", 0, 1'b0, 32'h400, '0, 7, 0, 7, 1, line_pat(0));

        // Stray ack while idle is ignored.
        stray = 1'b1;
        #1;
        check("stray m0 ack", 256'(m0_ack_o), 256'(0));
        check("stray m1 ack", 256'(m1_ack_o), 256'(0));
        check("stray m0 data", m0_data_o, '0);
        @(negedge clk_i);
        check("stray grant", 256'(grant_o), 256'(0));
        stray = 1'b0;

        txn("wr1", 1, 1'b1, 32'h20, {32{8'hA5}}, 3, 0, 3, 1, '0);
        check("wr1 mem line", mem[1], {32{8'hA5}});

        // Ack in the expiry cycle wins: acked, no error.
        txn("edge", 0, 1'b0, 32'h60, '0, Timeout, 0, Timeout, 1, line_pat(3));
        check("edge err", 256'(timeout_err_o), 256'(0));

        txn("drop", 0, 1'b0, 32'h40, '0, 4, 1, 4, 0, '0);
        check("drop err", 256'(timeout_err_o), 256'(0));

        txn("tmo", 1, 1'b0, 32'h80, '0, 0, 0, Timeout, 0, '0);
        check("tmo err", 256'(timeout_err_o), 256'(1));
        txn("post tmo", 1, 1'b0, 32'h60, '0, 2, 0, 2, 1, line_pat(3));
        check("post tmo err sticky", 256'(timeout_err_o), 256'(1));

        // Reset in the third BUSY0 cycle.
        ack_dly = 10;
        m0_write_i = 1'b0; m0_addr_i = 32'h400; m0_data_i = {8{32'h1234_5678}};
        m0_req_i = 1'b1;
        busy = 0;
        for (int c = 0; c < 20 && busy < 3; c++) begin
            @(negedge clk_i);
            if (mem_enable_o) busy++;
        end
        check("rst reached busy3", 256'(busy), 256'(3));
        rst_i = 1'b0;
        #1;
        check("rst enable", 256'(mem_enable_o), 256'(0));
        check("rst grant", 256'(grant_o), 256'(0));
        check("rst m0 ack", 256'(m0_ack_o), 256'(0));
        check("rst mem_addr", 256'(mem_addr_o), 256'(0));
        check("rst mem_data", mem_data_o, '0);
        check("rst err cleared", 256'(timeout_err_o), 256'(0));
        @(negedge clk_i);
        check("rst hold m0 ack", 256'(m0_ack_o), 256'(0));
        m0_req_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst idle grant", 256'(grant_o), 256'(0));
        check("rst idle enable", 256'(mem_enable_o), 256'(0));
        txn("after rst", 0, 1'b0, 32'h400, '0, 3, 0, 3, 1, line_pat(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
